// File: rtl/orbit_pkg.sv
// Shared screen geometry, FSM state encoding and pixel type for the orbit
// plotter datapath.
package orbit_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIX_X_W  = 10;
  localparam int PIX_Y_W  = 9;

  localparam logic [7:0] COLOR_ORBIT_DEF = 8'hFF;
  localparam logic [7:0] COLOR_BG_DEF    = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    MAP,
    ERASE,
    DRAW
  } state_e;

  typedef struct packed {
    logic [PIX_X_W-1:0] x;
    logic [PIX_Y_W-1:0] y;
  } pixel_t;

endpackage

// File: rtl/trail_ring.sv
// Ring buffer of recently drawn pixels; head is the oldest entry, read
// combinationally so the parent can erase it without a fetch cycle.
module trail_ring
  import orbit_pkg::*;
#(
  parameter  int TRAIL_LEN = 64,
  localparam int PTR_W     = $clog2(TRAIL_LEN),
  localparam int CNT_W     = $clog2(TRAIL_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  pixel_t           push_data,
  output pixel_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  pixel_t           mem [TRAIL_LEN];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(TRAIL_LEN));
  assign empty   = (count_q == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count and pointers
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/orbit_pixel_mapper.sv
// Maps orbital X/Y samples in metres onto 640x480 pixels, clips off-screen
// samples, and keeps a fixed-length trail by erasing the oldest pixel first.
module orbit_pixel_mapper
  import orbit_pkg::*;
#(
  parameter int         SCALE_SHIFT = 16,
  parameter int         CX          = 320,
  parameter int         CY          = 240,
  parameter int         TRAIL_LEN   = 64,
  parameter logic [7:0] COLOR_ORBIT = COLOR_ORBIT_DEF,
  parameter logic [7:0] COLOR_BG    = COLOR_BG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  in_x,
  input  logic signed [31:0]  in_y,
  output logic                pix_req,
  input  logic                pix_ack,
  output logic [PIX_X_W-1:0]  pix_x,
  output logic [PIX_Y_W-1:0]  pix_y,
  output logic [7:0]          pix_color,
  output logic [15:0]         clip_cnt,
  output logic                busy
);

  localparam int CNT_W = $clog2(TRAIL_LEN + 1);
  localparam logic signed [32:0] ORG_X = 33'(CX);
  localparam logic signed [32:0] ORG_Y = 33'(CY);
  localparam logic signed [32:0] LIM_X = 33'(SCREEN_W);
  localparam logic signed [32:0] LIM_Y = 33'(SCREEN_H);

  state_e              state_q, state_d;
  logic signed [31:0]  x_q, x_d, y_q, y_d;
  pixel_t              tgt_q, tgt_d, last_q, last_d;
  logic                last_valid_q, last_valid_d;
  logic                pix_req_q, pix_req_d;
  logic [PIX_X_W-1:0]  pix_x_q, pix_x_d;
  logic [PIX_Y_W-1:0]  pix_y_q, pix_y_d;
  logic [7:0]          pix_color_q, pix_color_d;
  logic [15:0]         clip_q, clip_d;

  logic signed [32:0]  sx, sy, px, py;
  logic                on_screen;
  pixel_t              map_pix;

  pixel_t              trail_head;
  logic [CNT_W-1:0]    trail_count;
  logic                trail_full, trail_empty;
  logic                trail_push, trail_pop;

  // Sign-extend before shifting so the floor behaviour holds for negatives.
  always_comb begin
    sx        = $signed({x_q[31], x_q}) >>> SCALE_SHIFT;
    sy        = $signed({y_q[31], y_q}) >>> SCALE_SHIFT;
    px        = ORG_X + sx;
    py        = ORG_Y - sy;
    on_screen = !px[32] && (px < LIM_X) && !py[32] && (py < LIM_Y);
    map_pix   = '{x: px[PIX_X_W-1:0], y: py[PIX_Y_W-1:0]};
  end

  assign trail_push = (state_q == DRAW)  && pix_ack && !trail_full;
  assign trail_pop  = (state_q == ERASE) && pix_ack && !trail_empty;

  trail_ring #(
    .TRAIL_LEN (TRAIL_LEN)
  ) u_trail (
    .clk       (clk),
    .rst       (rst),
    .push      (trail_push),
    .pop       (trail_pop),
    .push_data (tgt_q),
    .head      (trail_head),
    .count     (trail_count),
    .full      (trail_full),
    .empty     (trail_empty)
  );

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    tgt_d        = tgt_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    pix_req_d    = pix_req_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_color_d  = pix_color_q;
    clip_d       = clip_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          state_d = MAP;
        end
      end
      MAP: begin
        if (!on_screen) begin
          if (clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
          state_d = IDLE;
        end else if (last_valid_q && (map_pix == last_q)) begin
          state_d = IDLE;
        end else begin
          tgt_d     = map_pix;
          pix_req_d = 1'b1;
          if (trail_count == CNT_W'(TRAIL_LEN)) begin
            pix_x_d     = trail_head.x;
            pix_y_d     = trail_head.y;
            pix_color_d = COLOR_BG;
            state_d     = ERASE;
          end else begin
            pix_x_d     = map_pix.x;
            pix_y_d     = map_pix.y;
            pix_color_d = COLOR_ORBIT;
            state_d     = DRAW;
          end
        end
      end
      ERASE: begin
        if (pix_ack) begin
          pix_x_d     = tgt_q.x;
          pix_y_d     = tgt_q.y;
          pix_color_d = COLOR_ORBIT;
          state_d     = DRAW;
        end
      end
      DRAW: begin
        if (pix_ack) begin
          last_d       = tgt_q;
          last_valid_d = 1'b1;
          pix_req_d    = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      tgt_q        <= '0;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      pix_req_q    <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_color_q  <= '0;
      clip_q       <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      tgt_q        <= tgt_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      pix_req_q    <= pix_req_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_color_q  <= pix_color_d;
      clip_q       <= clip_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign pix_req   = pix_req_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign clip_cnt  = clip_q;

endmodule

// File: tb/tb_orbit_pixel_mapper.sv
// Directed bench for orbit_pixel_mapper with a 4-deep trail so erase and
// pointer wrap are reached with few samples.
module tb_orbit_pixel_mapper;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_x;
  logic signed [31:0] in_y;
  logic               pix_req;
  logic               pix_ack;
  logic [9:0]         pix_x;
  logic [8:0]         pix_y;
  logic [7:0]         pix_color;
  logic [15:0]        clip_cnt;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int rq_x[$];
  int rq_y[$];
  int rq_c[$];
  int nreq;
  int ncyc;

  orbit_pixel_mapper #(
    .TRAIL_LEN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .pix_req   (pix_req),
    .pix_ack   (pix_ack),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .clip_cnt  (clip_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample for a single cycle and records every accepted pixel
  // request until in_ready returns; ncyc counts cycles from acceptance.
  task automatic send(input logic signed [31:0] x, input logic signed [31:0] y);
    rq_x.delete();
    rq_y.delete();
    rq_c.delete();
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    ncyc     = 1;
    while (in_ready !== 1'b1 && ncyc < 40) begin
      if (pix_req === 1'b1 && pix_ack === 1'b1) begin
        rq_x.push_back(int'(pix_x));
        rq_y.push_back(int'(pix_y));
        rq_c.push_back(int'(pix_color));
      end
      tick();
      ncyc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout in_ready got %b exp 1 after %0d cycles", in_ready, ncyc);
    end
    nreq = rq_x.size();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    pix_ack  = 1'b1;
    tick();
    tick();
    checks++;
    if ({in_ready, pix_req, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b req=%b busy=%b exp 1 0 0", in_ready, pix_req, busy);
    end
    checks++;
    if ({pix_x, pix_y, pix_color} !== 27'd0) begin
      errors++;
      $display("FAIL reset_pix got (%0d,%0d,%h) exp (0,0,00)", pix_x, pix_y, pix_color);
    end
    checks++;
    if (clip_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_clip got %h exp 0000", clip_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_draw_latency();
    in_x     = 32'sd6771000;
    in_y     = 32'sd0;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_accept in_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready, pix_req} !== 3'b100) begin
      errors++;
      $display("FAIL lat_map got busy=%b rdy=%b req=%b exp 1 0 0", busy, in_ready, pix_req);
    end
    tick();
    checks++;
    if ({pix_req, pix_x, pix_y, pix_color} !== {1'b1, 10'd423, 9'd240, 8'hFF}) begin
      errors++;
      $display("FAIL lat_req got req=%b (%0d,%0d,%h) exp req=1 (423,240,ff)", pix_req, pix_x, pix_y, pix_color);
    end
    tick();
    checks++;
    if ({in_ready, pix_req} !== 2'b10) begin
      errors++;
      $display("FAIL lat_done got rdy=%b req=%b exp 1 0", in_ready, pix_req);
    end
  endtask

  // Floor shift for negatives plus the on-screen corner boundaries.
  task automatic test_floor_bounds();
    int vx[3];
    int vy[3];
    int ex[3];
    int ey[3];
    vx = '{0, 319 * 65536, -320 * 65536};
    vy = '{-6771000, 240 * 65536, -239 * 65536};
    ex = '{320, 639, 0};
    ey = '{344, 0, 479};
    for (int i = 0; i < 3; i++) begin
      send(vx[i], vy[i]);
      checks++;
      if (nreq != 1 || ncyc != 3) begin
        errors++;
        $display("FAIL floor_%0d_shape got reqs=%0d cycles=%0d exp 1 3", i, nreq, ncyc);
      end else begin
        checks++;
        if (rq_x[0] != ex[i] || rq_y[0] != ey[i] || rq_c[0] != 255) begin
          errors++;
          $display("FAIL floor_%0d_pix got (%0d,%0d,%0d) exp (%0d,%0d,255)", i, rq_x[0], rq_y[0], rq_c[0], ex[i], ey[i]);
        end
      end
    end
  endtask

  task automatic test_clip();
    logic [31:0] vx[4];
    logic [31:0] vy[4];
    logic [15:0] sat_exp[3];
    vx = '{32'h7FFF_FFFF, 32'(320 * 65536), 32'd0, 32'(-320 * 65536 - 1)};
    vy = '{32'd0, 32'd0, 32'(-240 * 65536), 32'd0};
    for (int i = 0; i < 4; i++) begin
      send(vx[i], vy[i]);
      checks++;
      if (nreq != 0 || ncyc != 2 || clip_cnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL clip_%0d got reqs=%0d cycles=%0d cnt=%0d exp 0 2 %0d", i, nreq, ncyc, clip_cnt, i + 1);
      end
    end
    // Preload near the top instead of issuing 65k clips to reach saturation.
    dut.clip_q = 16'hFFFD;
    sat_exp = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      send(32'h7FFF_FFFF, 32'd0);
      checks++;
      if (nreq != 0 || clip_cnt !== sat_exp[i]) begin
        errors++;
        $display("FAIL clip_sat_%0d got reqs=%0d cnt=%h exp 0 %h", i, nreq, clip_cnt, sat_exp[i]);
      end
    end
  endtask

  task automatic test_trail_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      send(k * 65536, 0);
      if (k <= 4) begin
        checks++;
        if (nreq != 1 || ncyc != 3) begin
          errors++;
          $display("FAIL wrap_%0d_shape got reqs=%0d cycles=%0d exp 1 3", k, nreq, ncyc);
        end else begin
          checks++;
          if (rq_x[0] != 320 + k || rq_y[0] != 240 || rq_c[0] != 255) begin
            errors++;
            $display("FAIL wrap_%0d_draw got (%0d,%0d,%0d) exp (%0d,240,255)", k, rq_x[0], rq_y[0], rq_c[0], 320 + k);
          end
        end
      end else begin
        checks++;
        if (nreq != 2 || ncyc != 4) begin
          errors++;
          $display("FAIL wrap_%0d_shape got reqs=%0d cycles=%0d exp 2 4", k, nreq, ncyc);
        end else begin
          checks++;
          if (rq_x[0] != 316 + k || rq_y[0] != 240 || rq_c[0] != 0 ||
              rq_x[1] != 320 + k || rq_y[1] != 240 || rq_c[1] != 255) begin
            errors++;
            $display("FAIL wrap_%0d_pair got (%0d,%0d,%0d)(%0d,%0d,%0d) exp (%0d,240,0)(%0d,240,255)",
                     k, rq_x[0], rq_y[0], rq_c[0], rq_x[1], rq_y[1], rq_c[1], 316 + k, 320 + k);
          end
        end
      end
    end
  endtask

  task automatic test_duplicate();
    int draws;
    send(13 * 65536, 0);
    checks++;
    if (nreq != 0 || ncyc != 2) begin
      errors++;
      $display("FAIL dup_last got reqs=%0d cycles=%0d exp 0 2", nreq, ncyc);
    end
    draws = 0;
    send(20 * 65536, 0);
    foreach (rq_c[i]) if (rq_c[i] == 255) draws++;
    checks++;
    if (nreq != 2 || rq_x[0] != 330 || rq_c[0] != 0) begin
      errors++;
      $display("FAIL dup_first got reqs=%0d erase_x=%0d exp 2 330", nreq, nreq > 0 ? rq_x[0] : -1);
    end
    send(20 * 65536, 0);
    foreach (rq_c[i]) if (rq_c[i] == 255) draws++;
    checks++;
    if (draws != 1 || nreq != 0) begin
      errors++;
      $display("FAIL dup_twice got draws=%0d second_reqs=%0d exp 1 0", draws, nreq);
    end
  endtask

  task automatic test_stall();
    pix_ack  = 1'b0;
    in_x     = 21 * 65536;
    in_y     = 0;
    in_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({pix_req, in_ready, pix_x, pix_y, pix_color} !== {1'b1, 1'b0, 10'd331, 9'd240, 8'h00}) begin
        errors++;
        $display("FAIL stall_hold_%0d got req=%b rdy=%b (%0d,%0d,%h) exp req=1 rdy=0 (331,240,00)",
                 i, pix_req, in_ready, pix_x, pix_y, pix_color);
      end
      if (i < 6) tick();
    end
    in_valid = 1'b0;
    pix_ack  = 1'b1;
    tick();
    checks++;
    if ({pix_req, pix_x, pix_y, pix_color} !== {1'b1, 10'd341, 9'd240, 8'hFF}) begin
      errors++;
      $display("FAIL stall_draw got req=%b (%0d,%0d,%h) exp req=1 (341,240,ff)", pix_req, pix_x, pix_y, pix_color);
    end
    tick();
    checks++;
    if ({in_ready, pix_req} !== 2'b10) begin
      errors++;
      $display("FAIL stall_done got rdy=%b req=%b exp 1 0", in_ready, pix_req);
    end
  endtask

  task automatic test_reset_mid();
    in_x     = 30 * 65536;
    in_y     = 0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    pix_ack = 1'b0;
    checks++;
    if ({pix_req, pix_x, pix_color} !== {1'b1, 10'd350, 8'hFF}) begin
      errors++;
      $display("FAIL rmid_wait got req=%b x=%0d col=%h exp req=1 350 ff", pix_req, pix_x, pix_color);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({pix_req, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL rmid_after got req=%b rdy=%b busy=%b exp 0 1 0", pix_req, in_ready, busy);
    end
    rst     = 1'b0;
    pix_ack = 1'b1;
    tick();
    for (int k = 31; k <= 34; k++) begin
      send(k * 65536, 0);
      checks++;
      if (nreq != 1 || ncyc != 3 || rq_x[0] != 320 + k || rq_c[0] != 255) begin
        errors++;
        $display("FAIL rmid_fill_%0d got reqs=%0d cycles=%0d exp 1 3 x=%0d", k, nreq, ncyc, 320 + k);
      end
    end
    send(35 * 65536, 0);
    checks++;
    if (nreq != 2 || rq_x[0] != 351 || rq_c[0] != 0 || rq_x[1] != 355 || rq_c[1] != 255) begin
      errors++;
      $display("FAIL rmid_erase got reqs=%0d exp 2 with erase 351 then draw 355", nreq);
    end
  endtask

  initial begin
    test_reset();
    test_draw_latency();
    test_floor_bounds();
    test_clip();
    test_trail_wrap();
    test_duplicate();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
